// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin arbiter and sequencer for the 16:1 one-bit mux.
// Shares the mux among 16 requesters, drives a registered select and one-hot
// grant, and presents din[sel] through a valid/ready handshake. Each grant is
// bounded by MAX_BEATS transferred beats and is always followed by one idle
// cycle before the next arbitration.
// Optional build macro MUX16_ARB_MASK_EN adds a per-channel enable input
// chan_en; the effective request becomes req & chan_en.
module mux16_rr_arbiter #(
  parameter int MAX_BEATS = 8,
  parameter int N_CH      = 16,
  parameter int SEL_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH-1:0]   din,
  output logic [SEL_W-1:0]  sel,
  output logic [N_CH-1:0]   gnt,
  output logic              out_valid,
  output logic              out_bit,
  input  logic              out_ready,
  output logic              busy
`ifdef MUX16_ARB_MASK_EN
  ,
  input  logic [N_CH-1:0]   chan_en
`endif
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q;
  state_t             state_d;
  logic [SEL_W-1:0]   ptr;
  logic [7:0]         beat_cnt;
  logic [N_CH-1:0]    eff_req;
  logic [SEL_W-1:0]   win;
  logic [SEL_W-1:0]   idx;
  logic               cur_req;
  logic               beat;
  logic               last_beat;
  logic               release_now;
  logic               load_grant;

`ifdef MUX16_ARB_MASK_EN
  assign eff_req = req & chan_en;
`else
  assign eff_req = req;
`endif

  // Handshake: valid only while granted and the owner still requests.
  assign cur_req     = eff_req[sel];
  assign busy        = (state_q == GRANT);
  assign out_valid   = busy && cur_req;
  assign out_bit     = out_valid && din[sel];
  assign beat        = out_valid && out_ready;
  assign last_beat   = beat && (beat_cnt == 8'(MAX_BEATS - 1));
  assign release_now = busy && (!cur_req || last_beat);
  assign load_grant  = (state_q == IDLE) && (|eff_req);

  // Round-robin search: first set request at or after ptr, wrapping mod 16.
  always_comb begin
    win = ptr;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (eff_req[idx]) begin
        win = idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: arbitrate from IDLE, leave GRANT on budget end or withdrawal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_grant)  state_d = GRANT;
      GRANT:   if (release_now) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant, select, pointer and beat budget bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel      <= '0;
      gnt      <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else if (load_grant) begin
      sel      <= win;
      gnt      <= {{(N_CH-1){1'b0}}, 1'b1} << win;
      beat_cnt <= '0;
    end else if (release_now) begin
      gnt      <= '0;
      ptr      <= sel + 1'b1;
    end else if (beat) begin
      beat_cnt <= beat_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: directed and randomized checks of mux16_rr_arbiter
// against a behavioural model of owner / budget / round-robin pointer.
module tb_mux16_rr_arbiter;

  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic [15:0] din;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        out_valid;
  logic        out_bit;
  logic        out_ready;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Behavioural model: owner channel (-1 when idle), beats done, next start.
  int m_owner;
  int m_cnt;
  int m_ptr;
  int m_sel;

  mux16_rr_arbiter #(.MAX_BEATS(MAXB)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .din(din),
    .sel(sel),
    .gnt(gnt),
    .out_valid(out_valid),
    .out_bit(out_bit),
    .out_ready(out_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_ptr   = 0;
    m_sel   = 0;
  endtask

  task automatic check_outputs();
    logic [15:0] eg;
    logic        ev;
    logic        eb;
    eg = 16'h0;
    ev = 1'b0;
    eb = 1'b0;
    if (m_owner >= 0) begin
      eg = 16'h1 << m_owner;
      ev = req[m_owner];
      eb = ev && din[m_owner];
    end
    chk("gnt", gnt, eg);
    chk("sel", {12'h0, sel}, 16'(m_sel));
    chk("out_valid", {15'h0, out_valid}, {15'h0, ev});
    chk("out_bit", {15'h0, out_bit}, {15'h0, eb});
    chk("busy", {15'h0, busy}, {15'h0, (m_owner >= 0)});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 16'h0);
    chk({tag, "_sel"}, {12'h0, sel}, 16'h0);
    chk({tag, "_valid"}, {15'h0, out_valid}, 16'h0);
    chk({tag, "_bit"}, {15'h0, out_bit}, 16'h0);
    chk({tag, "_busy"}, {15'h0, busy}, 16'h0);
  endtask

  // One clock cycle: starts and ends just after a falling edge.
  task automatic cycle(input logic [15:0] r, input logic [15:0] d, input logic rdy);
    bit found;
    int c;
    req       = r;
    din       = d;
    out_ready = rdy;
    #1;
    check_outputs();
    if (m_owner < 0) begin
      found = 1'b0;
      for (int i = 0; i < 16; i++) begin
        c = (m_ptr + i) % 16;
        if (!found && r[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_sel   = c;
          m_cnt   = 0;
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % 16;
      m_owner = -1;
    end else if (rdy) begin
      m_cnt++;
      if (m_cnt == MAXB) begin
        m_ptr   = (m_owner + 1) % 16;
        m_owner = -1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] r;
    // Test 1: reset with no clock edge yet, then idle with req=0.
    rst       = 1'b1;
    req       = 16'h0;
    din       = 16'hFFFF;
    out_ready = 1'b0;
    model_reset();
    #2;
    check_zero("rst_noclk");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) cycle(16'h0, 16'($urandom), 1'b1);

    // Test 2: single requester ch5, 8 beats, idle, regrant.
    cycle(16'h0020, 16'hFAC7, 1'b1);
    #1;
    chk("t2_sel", {12'h0, sel}, 16'd5);
    chk("t2_gnt", gnt, 16'h0020);
    chk("t2_bit", {15'h0, out_bit}, 16'h0);
    repeat (20) cycle(16'h0020, 16'hFAC7, 1'b1);

    // Test 3: fairness with wrap between ch0 and ch15.
    repeat (2) cycle(16'h0, 16'h0, 1'b1);
    repeat (24) cycle(16'h8001, 16'($urandom), 1'b1);

    // Test 4: backpressure on ch3 after beat 2.
    repeat (2) cycle(16'h0, 16'h0, 1'b1);
    repeat (3) cycle(16'h0008, 16'($urandom), 1'b1);
    repeat (3) cycle(16'h0008, 16'($urandom), 1'b0);
    repeat (10) cycle(16'h0008, 16'($urandom), 1'b1);

    // Test 5: withdrawal of ch9 after 2 beats, next search starts at ch10.
    repeat (2) cycle(16'h0, 16'h0, 1'b1);
    repeat (3) cycle(16'h0200, 16'hFFFF, 1'b1);
    repeat (4) cycle(16'h0001, 16'hFFFF, 1'b1);

    // Test 6: asynchronous reset in the middle of a ch12 grant.
    repeat (2) cycle(16'h0, 16'h0, 1'b1);
    repeat (3) cycle(16'h1000, 16'hFFFF, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(16'hFFFF, 16'hFFFF, 1'b1);
    #1;
    chk("t6_gnt", gnt, 16'h0001);
    repeat (4) cycle(16'hFFFF, 16'($urandom), 1'b1);

    // Randomized traffic with sparse requests, holds and backpressure.
    r = 16'h0;
    repeat (500) begin
      if ($urandom_range(0, 3) == 0) r = 16'($urandom & $urandom & $urandom);
      cycle(r, 16'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
